ram_write_arbiter: RTL and testbench
====================================

RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, per-requester FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter ADDR_WIDTH, default 12, RAM word-address width.
REQ-003 Parameter DATA_WIDTH, default 32, RAM word width.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pause  input  1  when high, no new RAM write is issued; FIFOs still accept.
REQ-007 uart_valid  input  1  requester 0 (UART loader) write request.
REQ-008 uart_addr  input  ADDR_WIDTH  requester 0 target address.
REQ-009 uart_data  input  DATA_WIDTH  requester 0 write data.
REQ-010 uart_ready  output  1  requester 0 FIFO not full.
REQ-011 sd_valid  input  1  requester 1 (SD block reader) write request.
REQ-012 sd_addr  input  ADDR_WIDTH  requester 1 target address.
REQ-013 sd_data  input  DATA_WIDTH  requester 1 write data.
REQ-014 sd_ready  output  1  requester 1 FIFO not full.
REQ-015 ram_wEn  output  1  RAM second-port write enable, registered.
REQ-016 ram_addr  output  ADDR_WIDTH  RAM second-port address, registered.
REQ-017 ram_dataIn  output  DATA_WIDTH  RAM second-port data, registered.
REQ-018 busy  output  1  high while either FIFO is non-empty or ram_wEn is high.
REQ-019 write_count  output  16  number of RAM writes issued since reset.

Function
REQ-020 Push into a requester's FIFO SHALL occur on a rising edge where valid && ready; valid without ready SHALL be ignored with no side effect.
REQ-021 ready SHALL equal "FIFO not full" and SHALL NOT depend on a same-cycle pop (a full FIFO accepts nothing that cycle).
REQ-022 Each cycle with pause low and at least one FIFO non-empty, exactly one FIFO SHALL be popped.
REQ-023 Arbitration SHALL be round-robin: when both FIFOs are non-empty, grant the requester not granted last; with one non-empty, grant it; last-grant pointer updates only on a grant.
REQ-024 A popped entry SHALL appear on ram_addr/ram_dataIn with ram_wEn=1 in the cycle after the pop; ram_wEn SHALL be 0 in any cycle following a no-pop cycle.
REQ-025 Latency: an entry pushed at edge k into an empty, uncontended FIFO SHALL drive ram_wEn=1 in the cycle following edge k+1.
REQ-026 ram_addr/ram_dataIn SHALL hold their last values when ram_wEn=0.
REQ-027 Per-requester ordering SHALL be preserved (FIFO); no cross-requester ordering guarantee.
REQ-028 Simultaneous push and pop on a non-full, non-empty FIFO SHALL both take effect; occupancy unchanged.
REQ-029 Push into an empty FIFO and pop of that same entry SHALL NOT occur in the same cycle (no fall-through).
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-031 write_count SHALL increment by 1 on every cycle ram_wEn=1, wrapping 0xFFFF -> 0x0000.
REQ-032 Asserting pause SHALL block pops from the next edge; a write already registered SHALL still complete.

Reset
REQ-033 On reset: both FIFOs empty, uart_ready=sd_ready=1, ram_wEn=0, ram_addr=0, ram_dataIn=0, busy=0, write_count=0, last-grant pointer = requester 1 (so requester 0 wins first tie).
REQ-034 Reset mid-operation SHALL discard all buffered entries; a write in flight SHALL be dropped (ram_wEn low immediately).

Structure
REQ-035 Shared package SHALL hold ADDR_WIDTH/DATA_WIDTH defaults, REQ_UART=0 and REQ_SD=1 index constants.
REQ-036 One sub-module write_fifo (synchronous FIFO, {addr,data} entry, full/empty outputs) SHALL be instantiated once per requester.

Verification
REQ-037 Single push uart addr=0x010 data=0xDEADBEEF at edge k -> ram_wEn=1, ram_addr=0x010, ram_dataIn=0xDEADBEEF in cycle after edge k+1; write_count=1.
REQ-038 Both valid every cycle, 8 writes each (uart 0x000-0x007, sd 0x100-0x107) -> RAM writes alternate uart,sd,uart,sd...; each stream in order; write_count=16; busy falls after last write.
REQ-039 pause=1, push 5 uart writes with DEPTH=4 -> uart_ready=0 after 4th accept, 5th held; release pause -> 5 writes in order, no loss.
REQ-040 Reset asserted with 3 entries buffered and ram_wEn=1 -> ram_wEn=0 immediately, busy=0, write_count=0, no further writes after reset release.
REQ-041 Preload write_count to 0xFFFF via 65535 writes, issue one more -> write_count=0x0000.

Source files
------------

// File: rtl/ram_write_arbiter_pkg.sv
// Shared constants and the round-robin pick helper for the two-requester RAM write arbiter.
package ram_write_arbiter_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 12;
    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int NUM_REQ            = 2;
    localparam int REQ_UART           = 0;
    localparam int REQ_SD             = 1;
    localparam int WRITE_COUNT_WIDTH  = 16;

    typedef enum logic {
        GRANT_UART = 1'b0,
        GRANT_SD   = 1'b1
    } grant_e;

    // One-hot grant: on a tie the requester that did not win last time goes next.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input grant_e last);
        logic [NUM_REQ-1:0] grant;
        grant = req;
        if (req[REQ_UART] && req[REQ_SD]) begin
            grant = (last == GRANT_UART) ? 2'b10 : 2'b01;
        end
        return grant;
    endfunction

endpackage

// File: rtl/ram_write_arbiter_write_fifo.sv
// Synchronous FIFO holding {addr,data} write entries; head entry is visible on pop_data.
module write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 do_push;
    logic                 do_pop;

    // Both guards use registered occupancy, so a freshly pushed entry cannot fall through.
    assign full     = (count_q == CNT_WIDTH'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ram_write_arbiter.sv
// Merges UART-loader and SD-reader write streams onto one registered RAM write port, round-robin.
module ram_write_arbiter
    import ram_write_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         pause,
    input  logic                         uart_valid,
    input  logic [ADDR_WIDTH-1:0]        uart_addr,
    input  logic [DATA_WIDTH-1:0]        uart_data,
    output logic                         uart_ready,
    input  logic                         sd_valid,
    input  logic [ADDR_WIDTH-1:0]        sd_addr,
    input  logic [DATA_WIDTH-1:0]        sd_data,
    output logic                         sd_ready,
    output logic                         ram_wEn,
    output logic [ADDR_WIDTH-1:0]        ram_addr,
    output logic [DATA_WIDTH-1:0]        ram_dataIn,
    output logic                         busy,
    output logic [WRITE_COUNT_WIDTH-1:0] write_count
);

    localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;

    logic [ENTRY_WIDTH-1:0]       uart_entry;
    logic [ENTRY_WIDTH-1:0]       sd_entry;
    logic                         uart_full, uart_empty;
    logic                         sd_full, sd_empty;
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           grant;
    grant_e                       last_grant_q, last_grant_d;
    logic                         ram_wen_q, ram_wen_d;
    logic [ADDR_WIDTH-1:0]        ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]        ram_data_q, ram_data_d;
    logic [WRITE_COUNT_WIDTH-1:0] write_count_q, write_count_d;

    assign uart_ready = !uart_full;
    assign sd_ready   = !sd_full;
    assign req        = {!pause && !sd_empty, !pause && !uart_empty};
    assign grant      = rr_pick(req, last_grant_q);

    write_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_uart_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (uart_valid && uart_ready),
        .push_data ({uart_addr, uart_data}),
        .pop       (grant[REQ_UART]),
        .pop_data  (uart_entry),
        .full      (uart_full),
        .empty     (uart_empty)
    );

    write_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_sd_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (sd_valid && sd_ready),
        .push_data ({sd_addr, sd_data}),
        .pop       (grant[REQ_SD]),
        .pop_data  (sd_entry),
        .full      (sd_full),
        .empty     (sd_empty)
    );

    // Address and data only move on a pop, so the port holds its last write while idle.
    always_comb begin
        last_grant_d  = last_grant_q;
        ram_wen_d     = |grant;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        write_count_d = write_count_q + WRITE_COUNT_WIDTH'(ram_wen_q);
        if (grant[REQ_UART]) begin
            last_grant_d = GRANT_UART;
            ram_addr_d   = uart_entry[ENTRY_WIDTH-1:DATA_WIDTH];
            ram_data_d   = uart_entry[DATA_WIDTH-1:0];
        end else if (grant[REQ_SD]) begin
            last_grant_d = GRANT_SD;
            ram_addr_d   = sd_entry[ENTRY_WIDTH-1:DATA_WIDTH];
            ram_data_d   = sd_entry[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q  <= GRANT_SD;
            ram_wen_q     <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            write_count_q <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            ram_wen_q     <= ram_wen_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            write_count_q <= write_count_d;
        end
    end

    assign ram_wEn     = ram_wen_q;
    assign ram_addr    = ram_addr_q;
    assign ram_dataIn  = ram_data_q;
    assign write_count = write_count_q;
    assign busy        = !uart_empty || !sd_empty || ram_wen_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_ram_write_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          pause = 1'b0;
    logic          uart_valid = 1'b0;
    logic [AW-1:0] uart_addr = '0;
    logic [DW-1:0] uart_data = '0;
    logic          uart_ready;
    logic          sd_valid = 1'b0;
    logic [AW-1:0] sd_addr = '0;
    logic [DW-1:0] sd_data = '0;
    logic          sd_ready;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn;
    logic          busy;
    logic [15:0]   write_count;

    ram_write_arbiter #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pause       (pause),
        .uart_valid  (uart_valid),
        .uart_addr   (uart_addr),
        .uart_data   (uart_data),
        .uart_ready  (uart_ready),
        .sd_valid    (sd_valid),
        .sd_addr     (sd_addr),
        .sd_data     (sd_data),
        .sd_ready    (sd_ready),
        .ram_wEn     (ram_wEn),
        .ram_addr    (ram_addr),
        .ram_dataIn  (ram_dataIn),
        .busy        (busy),
        .write_count (write_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          uq[$];
    ent_t          sq[$];
    bit            m_last  = 1'b1;
    bit            m_wen   = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic [15:0]   m_count = '0;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] rec_addr[$];
    logic [DW-1:0] rec_data[$];

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one RAM write per non-paused cycle, taken from a queue chosen by alternation.
    always @(posedge clock or posedge reset) begin : model
        int   g;
        bit   up;
        bit   sp;
        ent_t e;
        if (reset) begin
            uq.delete();
            sq.delete();
            m_last  = 1'b1;
            m_wen   = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_count = '0;
        end else begin
            g = -1;
            if (!pause) begin
                if (uq.size() > 0 && sq.size() > 0) g = m_last ? 0 : 1;
                else if (uq.size() > 0)             g = 0;
                else if (sq.size() > 0)             g = 1;
            end
            up = uart_valid && (uq.size() < DEPTH);
            sp = sd_valid && (sq.size() < DEPTH);
            m_count = m_count + 16'(m_wen);
            m_wen   = (g >= 0);
            if (g == 0) begin
                e = uq.pop_front();
                m_addr = e.a;
                m_data = e.d;
                m_last = 1'b0;
            end else if (g == 1) begin
                e = sq.pop_front();
                m_addr = e.a;
                m_data = e.d;
                m_last = 1'b1;
            end
            if (up) uq.push_back({uart_addr, uart_data});
            if (sp) sq.push_back({sd_addr, sd_data});
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check_output("cmp_ram_wEn", ram_wEn, m_wen);
            check_output("cmp_ram_addr", ram_addr, m_addr);
            check_output("cmp_ram_dataIn", ram_dataIn, m_data);
            check_output("cmp_uart_ready", uart_ready, uq.size() < DEPTH);
            check_output("cmp_sd_ready", sd_ready, sq.size() < DEPTH);
            check_output("cmp_busy", busy, (uq.size() > 0) || (sq.size() > 0) || m_wen);
            check_output("cmp_write_count", write_count, m_count);
        end
    end

    task automatic apply_reset();
        uart_valid = 1'b0;
        sd_valid   = 1'b0;
        pause      = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drives both streams with valid/ready handshakes and logs every RAM write until idle.
    task automatic apply_stimulus(input int nu, input logic [AW-1:0] ua0, input logic [DW-1:0] ud0,
                                  input int ns, input logic [AW-1:0] sa0, input logic [DW-1:0] sd0,
                                  input int budget);
        int ui   = 0;
        int si   = 0;
        bit done = 1'b0;
        rec_addr.delete();
        rec_data.delete();
        for (int c = 0; c < budget && !done; c++) begin
            if (ui < nu) begin
                uart_valid = 1'b1;
                uart_addr  = ua0 + AW'(ui);
                uart_data  = ud0 + DW'(ui);
                if (uart_ready) ui++;
            end else begin
                uart_valid = 1'b0;
            end
            if (si < ns) begin
                sd_valid = 1'b1;
                sd_addr  = sa0 + AW'(si);
                sd_data  = sd0 + DW'(si);
                if (sd_ready) si++;
            end else begin
                sd_valid = 1'b0;
            end
            @(negedge clock);
            if (ram_wEn) begin
                rec_addr.push_back(ram_addr);
                rec_data.push_back(ram_dataIn);
            end
            if (ui >= nu && si >= ns && !busy) done = 1'b1;
        end
        uart_valid = 1'b0;
        sd_valid   = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL stream_timeout: got busy after %0d cycles, expected idle", budget);
        end
    endtask

    initial begin
        int n;
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        check_output("rst_wEn", ram_wEn, 1'b0);
        check_output("rst_addr", ram_addr, 0);
        check_output("rst_data", ram_dataIn, 0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_count", write_count, 0);
        check_output("rst_uart_ready", uart_ready, 1'b1);
        check_output("rst_sd_ready", sd_ready, 1'b1);
        reset = 1'b0;

        $display("[TB] single uart write latency");
        uart_valid = 1'b1;
        uart_addr  = 12'h010;
        uart_data  = 32'hDEADBEEF;
        @(negedge clock);
        uart_valid = 1'b0;
        check_output("single_wen_k", ram_wEn, 1'b0);
        check_output("single_busy_k", busy, 1'b1);
        @(negedge clock);
        check_output("single_wen_k1", ram_wEn, 1'b1);
        check_output("single_addr", ram_addr, 12'h010);
        check_output("single_data", ram_dataIn, 32'hDEADBEEF);
        @(negedge clock);
        check_output("single_wen_after", ram_wEn, 1'b0);
        check_output("single_addr_hold", ram_addr, 12'h010);
        check_output("single_count", write_count, 1);

        $display("[TB] round-robin with both streams");
        apply_reset();
        apply_stimulus(8, 12'h000, 32'hA000_0000, 8, 12'h100, 32'hB000_0000, 200);
        check_output("rr_nwrites", rec_addr.size(), 16);
        n = (rec_addr.size() < 16) ? rec_addr.size() : 16;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) begin
                check_output("rr_addr", rec_addr[i], 12'(i / 2));
                check_output("rr_data", rec_data[i], 32'hA000_0000 + 32'(i / 2));
            end else begin
                check_output("rr_addr", rec_addr[i], 12'h100 + 12'(i / 2));
                check_output("rr_data", rec_data[i], 32'hB000_0000 + 32'(i / 2));
            end
        end
        check_output("rr_count", write_count, 16);
        check_output("rr_busy_end", busy, 1'b0);

        $display("[TB] pause with full uart fifo");
        apply_reset();
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_valid = 1'b1;
            uart_addr  = 12'h200 + 12'(i);
            uart_data  = 32'hC000_0000 + 32'(i);
            @(negedge clock);
        end
        check_output("pause_ready_full", uart_ready, 1'b0);
        check_output("pause_sd_ready", sd_ready, 1'b1);
        uart_addr = 12'h204;
        uart_data = 32'hC000_0004;
        repeat (3) @(negedge clock);
        check_output("pause_ready_held", uart_ready, 1'b0);
        check_output("pause_no_write", ram_wEn, 1'b0);
        pause = 1'b0;
        apply_stimulus(1, 12'h204, 32'hC000_0004, 0, 12'h000, 32'h0, 50);
        check_output("pause_nwrites", rec_addr.size(), 5);
        n = (rec_addr.size() < 5) ? rec_addr.size() : 5;
        for (int i = 0; i < n; i++) begin
            check_output("pause_addr", rec_addr[i], 12'h200 + 12'(i));
            check_output("pause_data", rec_data[i], 32'hC000_0000 + 32'(i));
        end
        check_output("pause_count", write_count, 5);

        $display("[TB] reset mid-operation");
        apply_reset();
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_valid = 1'b1;
            uart_addr  = 12'h300 + 12'(i);
            uart_data  = 32'hD000_0000 + 32'(i);
            @(negedge clock);
        end
        uart_valid = 1'b0;
        pause      = 1'b0;
        @(negedge clock);
        check_output("midrst_wen_before", ram_wEn, 1'b1);
        check_output("midrst_addr_before", ram_addr, 12'h300);
        #2 reset = 1'b1;
        #1;
        check_output("midrst_wen", ram_wEn, 1'b0);
        check_output("midrst_busy", busy, 1'b0);
        check_output("midrst_count", write_count, 0);
        check_output("midrst_uart_ready", uart_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clock);
            if (ram_wEn) n++;
        end
        check_output("midrst_no_writes", n, 0);
        check_output("midrst_count_after", write_count, 0);

        $display("[TB] write_count wrap");
        apply_reset();
        apply_stimulus(65535, 12'h000, 32'h0, 0, 12'h000, 32'h0, 70000);
        check_output("wrap_count_ffff", write_count, 16'hFFFF);
        apply_stimulus(1, 12'h007, 32'h0000_1234, 0, 12'h000, 32'h0, 50);
        check_output("wrap_last_addr", (rec_addr.size() == 1) ? rec_addr[0] : 12'hFFF, 12'h007);
        check_output("wrap_count_zero", write_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
